// File: rtl/mem_access_unit.sv
// mem_access_unit: multi-cycle access engine for an external 32-bit
// asynchronous SRAM. Accepts LW/LB/SW/SB requests from the controller,
// sequences ce_n/oe_n/we_n with WAIT_CYCLES strobe cycles, returns load
// data (LB sign-extended) and pulses done at the end of the access.
// All outputs are registered; their next values are derived from the
// next FSM state so that strobes change cleanly on clock edges.
module mem_access_unit #(
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_WIDTH  = 20
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3:0]            mem_mode,
  input  logic [31:0]           addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [31:0]           ram_wdata,
  output logic                  ram_data_oe,
  input  logic [31:0]           ram_rdata,
  output logic                  ram_ce_n,
  output logic                  ram_oe_n,
  output logic                  ram_we_n,
  output logic [3:0]            ram_be_n
);

  // Access-mode encoding shared with the controller
  localparam logic [3:0] IO_NOP = 4'd0;
  localparam logic [3:0] IO_LW  = 4'd1;
  localparam logic [3:0] IO_LB  = 4'd2;
  localparam logic [3:0] IO_SW  = 4'd3;
  localparam logic [3:0] IO_SB  = 4'd4;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_ACCESS = 3'd2,
    S_HOLD   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [3:0]            r_cnt, w_cnt_nxt;
  logic [3:0]            r_mode, w_mode_nxt;
  logic [1:0]            r_lane, w_lane_nxt;
  logic [31:0]           r_rdata, w_rdata_nxt;
  logic                  r_busy, w_busy_nxt;
  logic                  r_done, w_done_nxt;
  logic [ADDR_WIDTH-1:0] r_ram_addr, w_ram_addr_nxt;
  logic [31:0]           r_ram_wdata, w_ram_wdata_nxt;
  logic                  r_data_oe, w_data_oe_nxt;
  logic                  r_ce_n, w_ce_n_nxt;
  logic                  r_oe_n, w_oe_n_nxt;
  logic                  r_we_n, w_we_n_nxt;
  logic [3:0]            r_be_n, w_be_n_nxt;
  logic                  w_accept;
  logic [3:0]            w_mode_eff;
  logic [1:0]            w_lane_eff;
  logic                  w_unused_addr_hi;

  // Address bits above the SRAM range simply wrap
  assign w_unused_addr_hi = ^addr[31:ADDR_WIDTH+2];

  function automatic logic f_is_store(input logic [3:0] mode);
    return (mode == IO_SW) || (mode == IO_SB);
  endfunction

  function automatic logic f_is_valid(input logic [3:0] mode);
    return (mode == IO_LW) || (mode == IO_LB) || (mode == IO_SW) || (mode == IO_SB);
  endfunction

  function automatic logic [3:0] f_byte_en_n(input logic [3:0] mode, input logic [1:0] lane);
    case (mode)
      IO_SB:               return ~(4'b0001 << lane);
      IO_LW, IO_LB, IO_SW: return 4'h0;
      default:             return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] f_store_data(input logic [3:0] mode, input logic [31:0] wd);
    if (mode == IO_SB) return {4{wd[7:0]}};
    else               return wd;
  endfunction

  function automatic logic [31:0] f_load_data(input logic [3:0] mode, input logic [1:0] lane,
                                              input logic [31:0] word);
    if (mode == IO_LB) begin
      case (lane)
        2'd0:    return {{24{word[7]}},  word[7:0]};
        2'd1:    return {{24{word[15]}}, word[15:8]};
        2'd2:    return {{24{word[23]}}, word[23:16]};
        2'd3:    return {{24{word[31]}}, word[31:24]};
        default: return 32'h0;
      endcase
    end else begin
      return word;
    end
  endfunction

  // Next-state, counter and next registered-output values
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_mode_nxt      = r_mode;
    w_lane_nxt      = r_lane;
    w_rdata_nxt     = r_rdata;
    w_ram_addr_nxt  = r_ram_addr;
    w_ram_wdata_nxt = r_ram_wdata;
    w_accept        = 1'b0;
    w_ce_n_nxt      = 1'b1;
    w_oe_n_nxt      = 1'b1;
    w_we_n_nxt      = 1'b1;
    w_be_n_nxt      = 4'hF;
    w_data_oe_nxt   = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (f_is_valid(mem_mode)) begin
          w_accept    = 1'b1;
          w_mode_nxt  = mem_mode;
          w_lane_nxt  = addr[1:0];
          w_state_nxt = S_SETUP;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_SETUP: begin
        w_cnt_nxt   = 4'(WAIT_CYCLES - 1);
        w_state_nxt = S_ACCESS;
      end
      S_ACCESS: begin
        if (r_cnt == 4'd0) begin
          if (f_is_store(r_mode)) begin
            w_state_nxt = S_HOLD;
          end else begin
            w_state_nxt = S_DONE;
            w_rdata_nxt = f_load_data(r_mode, r_lane, ram_rdata);
          end
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      S_HOLD:  w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    // On the accept edge the latched copies are not yet valid
    w_mode_eff = w_accept ? mem_mode  : r_mode;
    w_lane_eff = w_accept ? addr[1:0] : r_lane;

    case (w_state_nxt)
      S_SETUP: begin
        w_ce_n_nxt     = 1'b0;
        w_be_n_nxt     = f_byte_en_n(w_mode_eff, w_lane_eff);
        w_ram_addr_nxt = addr[ADDR_WIDTH+1:2];
        if (f_is_store(w_mode_eff)) begin
          w_data_oe_nxt   = 1'b1;
          w_ram_wdata_nxt = f_store_data(w_mode_eff, wdata);
        end else begin
          w_data_oe_nxt   = 1'b0;
        end
      end
      S_ACCESS: begin
        w_ce_n_nxt    = 1'b0;
        w_be_n_nxt    = f_byte_en_n(w_mode_eff, w_lane_eff);
        w_data_oe_nxt = f_is_store(w_mode_eff);
        w_we_n_nxt    = ~f_is_store(w_mode_eff);
        w_oe_n_nxt    = f_is_store(w_mode_eff);
      end
      S_HOLD: begin
        w_ce_n_nxt    = 1'b0;
        w_be_n_nxt    = f_byte_en_n(w_mode_eff, w_lane_eff);
        w_data_oe_nxt = 1'b1;
      end
      default: begin
        w_ce_n_nxt = 1'b1;
      end
    endcase

    w_busy_nxt = (w_state_nxt != S_IDLE);
    w_done_nxt = (w_state_nxt == S_DONE);
  end

  // State, latched request and registered outputs; reset forces strobes idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_mode      <= IO_NOP;
      r_lane      <= 2'd0;
      r_rdata     <= 32'h0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= 32'h0;
      r_data_oe   <= 1'b0;
      r_ce_n      <= 1'b1;
      r_oe_n      <= 1'b1;
      r_we_n      <= 1'b1;
      r_be_n      <= 4'hF;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_mode      <= w_mode_nxt;
      r_lane      <= w_lane_nxt;
      r_rdata     <= w_rdata_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_ram_addr  <= w_ram_addr_nxt;
      r_ram_wdata <= w_ram_wdata_nxt;
      r_data_oe   <= w_data_oe_nxt;
      r_ce_n      <= w_ce_n_nxt;
      r_oe_n      <= w_oe_n_nxt;
      r_we_n      <= w_we_n_nxt;
      r_be_n      <= w_be_n_nxt;
    end
  end

  assign rdata       = r_rdata;
  assign busy        = r_busy;
  assign done        = r_done;
  assign ram_addr    = r_ram_addr;
  assign ram_wdata   = r_ram_wdata;
  assign ram_data_oe = r_data_oe;
  assign ram_ce_n    = r_ce_n;
  assign ram_oe_n    = r_oe_n;
  assign ram_we_n    = r_we_n;
  assign ram_be_n    = r_be_n;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Multi-cycle SRAM access engine that sits between the multi-cycle controller/datapath and the external 32-bit asynchronous SRAM.
- Consumes the controller's access mode (IO_NOP/IO_LW/IO_LB/IO_SW/IO_SB from defs.v), the byte address (PC or C, per mem_src) and the store data (B).
- Sequences SRAM chip-enable, output-enable and write-enable timing, with a configurable number of wait cycles.
- Returns load data, or the fetched instruction, with LB sign-extension. Raises busy/done so the controller stalls its state until the access completes.

Parameters:
WAIT_CYCLES, 2, cycles the SRAM strobe (oe_n or we_n) is held active; legal range 1..15
ADDR_WIDTH, 20, SRAM word-address width; ram_addr = addr[ADDR_WIDTH+1:2]

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
mem_mode  in  4  access mode, defs.v IO_* encoding; held stable by requester until done
addr  in  32  byte address (PC or C)
wdata  in  32  store data
rdata  out  32  load result (LW: word; LB: sign-extended byte); valid from done cycle until next accept
busy  out  1  registered; high from the cycle after accept through the done cycle
done  out  1  one-cycle pulse, access complete
ram_addr  out  ADDR_WIDTH  SRAM word address
ram_wdata  out  32  SRAM write data
ram_data_oe  out  1  top-level tristate enable for ram_wdata
ram_rdata  in  32  SRAM read data
ram_ce_n  out  1  chip enable, active low
ram_oe_n  out  1  output enable, active low
ram_we_n  out  1  write enable, active low
ram_be_n  out  4  byte enables, active low, lane i = bits [8i+7:8i]

Behaviour:
- Reset (async, rst_n=0) values:
  - ram_ce_n=1, ram_oe_n=1, ram_we_n=1, ram_be_n=4'hF, ram_data_oe=0.
  - ram_addr=0, ram_wdata=0, rdata=0, busy=0, done=0.
  - FSM=IDLE, wait counter=0.
- Reset mid-access: strobes deassert immediately and asynchronously. The access is abandoned, no done pulse, rdata retains reset value.
- FSM states: IDLE, SETUP, ACCESS, HOLD, DONE.
- IDLE:
  - If mem_mode != IO_NOP, latch mode, addr, wdata and go to SETUP (this is the accept edge).
  - IO_NOP or unknown encoding: stay in IDLE.
  - mem_mode is ignored in every other state.
- SETUP (1 cycle):
  - Drive ram_addr and ram_be_n, ram_ce_n=0. oe_n and we_n stay high.
  - Stores: ram_data_oe=1, ram_wdata driven.
  - Counter loaded with WAIT_CYCLES-1. Go to ACCESS.
- ACCESS (WAIT_CYCLES cycles):
  - Loads: ram_oe_n=0. Stores: ram_we_n=0.
  - Counter decrements each cycle. When the counter is 0:
    - Loads: capture ram_rdata into the internal data register, go to DONE.
    - Stores: go to HOLD.
- HOLD (stores only, 1 cycle): ram_we_n=1, while ce_n, addr, data and oe stay driven (data hold time). Go to DONE.
- DONE (1 cycle):
  - done=1; all strobes deasserted (ce_n=1, be_n=4'hF, data_oe=0).
  - rdata updated (loads only; stores leave rdata unchanged).
  - Go to IDLE. A request present in the following IDLE cycle starts a new access.
- Latency from accept edge to done: loads 2+WAIT_CYCLES cycles, stores 3+WAIT_CYCLES cycles. Default: loads 4, stores 5.
- Byte lanes (little-endian):
  - LW/SW: be_n=4'h0; addr[1:0] ignored (treated as word-aligned).
  - LB: be_n=4'h0 on read; byte selected by latched addr[1:0] and sign-extended to 32 bits.
  - SB: be_n has only lane addr[1:0] low; wdata[7:0] replicated on all four lanes.
- Address bits above ADDR_WIDTH+1 are ignored (wrap into SRAM).
- busy is registered and is 0 in the accept cycle itself. The requester relies on holding mem_mode until done, not on busy in that cycle.

Test Plan:
1. LW at addr=0x0000_0010, ram_rdata=0xDEADBEEF -> ram_addr=0x4, be_n=0, oe_n low exactly 2 cycles, done 4 cycles after accept, rdata=0xDEADBEEF.
2. LB at addr=0x0000_0013 with word 0x80112233, then addr=0x...12 -> rdata=0xFFFFFF80, then 0x00000011.
3. SB addr=0x0000_0021, wdata=0x000000AB -> ram_addr=0x8, be_n=4'b1101, ram_wdata=0xABABABAB, we_n low 2 cycles bracketed by ce_n low with one HOLD cycle, done after 5 cycles, rdata unchanged.
4. WAIT_CYCLES=1; back-to-back LW/SW with mem_mode changed the cycle after done -> second access starts immediately, done pulses separated by 3+1 cycles; IO_NOP produces no SRAM activity.
5. rst_n low during SW ACCESS -> we_n/ce_n high asynchronously, no done, busy=0. Next LW after release completes normally.
6. mem_mode changed mid-access to IO_SW during a LW -> ignored; completes as a read with oe_n only, we_n never low.
